// File: rtl/turbine_frame_packer.sv
// Turbine frame packer: per-channel FWFT FIFOs feeding a fixed-length
// 16-bit framed stream (header, seq/info, one word per channel, mask, checksum).

module turbine_chan_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] dout,
  output logic        not_empty,
  output logic        ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          full, do_wr;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
  assign full      = (cnt == CW'(DEPTH));
  assign do_wr     = wr_en & (~full | pop);
  assign ovf       = wr_en & full & ~pop;
  assign dout      = mem[rd_ptr];
  assign not_empty = (cnt != '0);

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_wr) - CW'(pop);
    end
  end

  // Storage; contents are only ever read behind a nonzero count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end
endmodule

module turbine_frame_packer #(
  parameter int          TURBINE_NUM = 10,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] FRAME_HEAD  = 16'hEB90
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic [TURBINE_NUM-1:0]    wr_en_i,
  input  logic [TURBINE_NUM*16-1:0] wr_din_i,
  input  logic                      frame_req_pluse_i,
  input  logic                      ovf_clr_i,
  input  logic                      m_tready_i,
  output logic                      m_tvalid_o,
  output logic [15:0]               m_tdata_o,
  output logic                      m_tlast_o,
  output logic [TURBINE_NUM-1:0]    ovf_flag_o,
  output logic                      busy_o
);
  localparam int IW = (TURBINE_NUM > 1) ? $clog2(TURBINE_NUM) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_INFO, S_DATA, S_MASK, S_CSUM} state_t;

  state_t state, state_nxt;

  logic [TURBINE_NUM-1:0][15:0] fifo_dout;
  logic [TURBINE_NUM-1:0]       fifo_nz, fifo_ovf, fifo_pop;
  logic [TURBINE_NUM-1:0]       mask;
  logic [IW-1:0]                ch_idx;
  logic [7:0]                   seq;
  logic [15:0]                  csum, data_sel;
  logic                         hs, last_ch, req_acc;

  for (genvar k = 0; k < TURBINE_NUM; k++) begin : g_ch
    turbine_chan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (sys_clk_i),
      .rst       (rst_i),
      .wr_en     (wr_en_i[k]),
      .din       (wr_din_i[16*k +: 16]),
      .pop       (fifo_pop[k]),
      .dout      (fifo_dout[k]),
      .not_empty (fifo_nz[k]),
      .ovf       (fifo_ovf[k])
    );
  end

  assign m_tvalid_o = (state != S_IDLE);
  assign busy_o     = (state != S_IDLE);
  assign m_tlast_o  = (state == S_CSUM);
  assign hs         = m_tvalid_o & m_tready_i;
  assign last_ch    = (ch_idx == IW'(TURBINE_NUM - 1));
  assign req_acc    = (state == S_IDLE) & frame_req_pluse_i;

  // Current channel's slot word and its pop strobe (masked-out slots send zero, no pop).
  always_comb begin
    data_sel = '0;
    fifo_pop = '0;
    for (int k = 0; k < TURBINE_NUM; k++) begin
      if (ch_idx == IW'(k)) begin
        data_sel    = mask[k] ? fifo_dout[k] : 16'h0000;
        fifo_pop[k] = mask[k] & hs & (state == S_DATA);
      end
    end
  end

  // State register.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and output word; all words derive from registers so they hold under stall.
  always_comb begin
    state_nxt = state;
    m_tdata_o = 16'h0000;
    case (state)
      S_IDLE: if (frame_req_pluse_i) state_nxt = S_HEAD;
      S_HEAD: begin
        m_tdata_o = FRAME_HEAD;
        if (hs) state_nxt = S_INFO;
      end
      S_INFO: begin
        m_tdata_o = {seq, 8'(TURBINE_NUM)};
        if (hs) state_nxt = S_DATA;
      end
      S_DATA: begin
        m_tdata_o = data_sel;
        if (hs && last_ch) state_nxt = S_MASK;
      end
      S_MASK: begin
        m_tdata_o = 16'(mask);
        if (hs) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        m_tdata_o = csum;
        if (hs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame datapath: mask snapshot, channel index, checksum, sequence, sticky overflow.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask       <= '0;
      ch_idx     <= '0;
      csum       <= '0;
      seq        <= '0;
      ovf_flag_o <= '0;
    end else begin
      ovf_flag_o <= (ovf_flag_o & ~{TURBINE_NUM{ovf_clr_i}}) | fifo_ovf;
      if (req_acc) begin
        mask   <= fifo_nz;
        ch_idx <= '0;
        csum   <= '0;
      end else if (hs) begin
        csum <= csum + m_tdata_o;
        if (state == S_DATA) ch_idx <= ch_idx + 1'b1;
        if (state == S_CSUM) seq    <= seq + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_turbine_frame_packer.sv
// Directed bench for turbine_frame_packer (N=10, depth 4).
module tb_turbine_frame_packer;
  localparam int N = 10;
  localparam int D = 4;

  logic            sys_clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    wr_en_i = '0;
  logic [N*16-1:0] wr_din_i = '0;
  logic            frame_req_pluse_i = 1'b0;
  logic            ovf_clr_i = 1'b0;
  logic            m_tready_i = 1'b1;
  logic            m_tvalid_o, m_tlast_o, busy_o;
  logic [15:0]     m_tdata_o;
  logic [N-1:0]    ovf_flag_o;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_w [N+4];
  logic [15:0] got_w [N+4];
  logic [15:0] exp_d [N];

  turbine_frame_packer #(.TURBINE_NUM(N), .FIFO_DEPTH(D), .FRAME_HEAD(16'hEB90)) dut (
    .sys_clk_i(sys_clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_din_i(wr_din_i),
    .frame_req_pluse_i(frame_req_pluse_i), .ovf_clr_i(ovf_clr_i), .m_tready_i(m_tready_i),
    .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tlast_o(m_tlast_o),
    .ovf_flag_o(ovf_flag_o), .busy_o(busy_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected frame from seq, mask and exp_d; checksum summed here independently.
  task automatic mk_exp(input logic [7:0] s, input logic [N-1:0] m);
    logic [15:0] sum;
    exp_w[0] = 16'hEB90;
    exp_w[1] = {s, 8'(N)};
    for (int k = 0; k < N; k++) exp_w[2+k] = m[k] ? exp_d[k] : 16'h0000;
    exp_w[N+2] = 16'(m);
    sum = 16'h0000;
    for (int i = 0; i < N+3; i++) sum = sum + exp_w[i];
    exp_w[N+3] = sum;
  endtask

  task automatic do_write(input int ch, input logic [15:0] val);
    @(negedge sys_clk_i);
    wr_en_i = '0;
    wr_en_i[ch] = 1'b1;
    wr_din_i[ch*16 +: 16] = val;
  endtask

  task automatic idle;
    @(negedge sys_clk_i);
    wr_en_i = '0;
    ovf_clr_i = 1'b0;
  endtask

  // Caller is at a negedge. Requests, collects N+4 words, optionally toggles ready,
  // injects a request at word req_at, or writes a channel at word wr_at's handshake.
  task automatic run_frame(input string tag, input bit toggle, input int req_at,
                           input int wr_at, input int wr_ch, input logic [15:0] wr_val);
    int n = 0;
    int cyc = 0;
    bit rdy, stalled;
    logic [15:0] held_d;
    logic held_l;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    wr_en_i = '0;
    frame_req_pluse_i = 1'b1;
    @(negedge sys_clk_i);
    frame_req_pluse_i = 1'b0;
    chk({tag, " latency"}, {14'd0, m_tvalid_o, busy_o, m_tdata_o}, {14'd0, 2'b11, 16'hEB90});
    while (n < N+4 && cyc < 200) begin
      if (cyc > 0) @(negedge sys_clk_i);
      frame_req_pluse_i = 1'b0;
      wr_en_i = '0;
      rdy = toggle ? cyc[0] : 1'b1;
      m_tready_i = rdy;
      if (stalled)
        chk({tag, " hold"}, {m_tvalid_o, m_tlast_o, m_tdata_o}, {1'b1, held_l, held_d});
      if (!m_tvalid_o) begin
        chk({tag, " valid dropped"}, 32'(m_tvalid_o), 32'd1);
        break;
      end
      if (rdy) begin
        got_w[n] = m_tdata_o;
        chk($sformatf("%s last w%0d", tag, n), 32'(m_tlast_o), 32'(n == N+3));
        if (n == req_at) frame_req_pluse_i = 1'b1;
        if (n == wr_at) begin
          wr_en_i[wr_ch] = 1'b1;
          wr_din_i[wr_ch*16 +: 16] = wr_val;
        end
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d = m_tdata_o;
        held_l = m_tlast_o;
      end
      cyc++;
    end
    chk({tag, " words"}, 32'(n), 32'(N+4));
    @(negedge sys_clk_i);
    frame_req_pluse_i = 1'b0;
    wr_en_i = '0;
    m_tready_i = 1'b1;
    chk({tag, " end idle"}, {30'd0, m_tvalid_o, busy_o}, 32'd0);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s w%0d", tag, i), 32'(got_w[i]), 32'(exp_w[i]));
  endtask

  initial begin
    for (int k = 0; k < N; k++) exp_d[k] = 16'h0000;

    // Reset behaviour
    repeat (3) @(negedge sys_clk_i);
    chk("in reset", {m_tvalid_o, m_tlast_o, busy_o, ovf_flag_o, m_tdata_o},
        {3'b000, 10'd0, 16'h0000});
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk_i);
      chk($sformatf("post reset %0d", i), {m_tvalid_o, m_tlast_o, busy_o, m_tdata_o}, 32'd0);
    end

    // Basic frame: ch0=1234, ch3=ABCD
    do_write(0, 16'h1234);
    do_write(3, 16'hABCD);
    idle();
    exp_d[0] = 16'h1234;
    exp_d[3] = 16'hABCD;
    mk_exp(8'd0, 10'b00_0000_1001);
    run_frame("basic", 1'b0, -1, -1, 0, 16'h0);
    chk("basic mask lit", 32'(got_w[12]), 32'h0009);
    chk("basic csum lit", 32'(got_w[13]), 32'hA9A4);

    // Immediate second request: empty frame
    mk_exp(8'd1, 10'd0);
    run_frame("second", 1'b0, -1, -1, 0, 16'h0);
    chk("second csum lit", 32'(got_w[13]), 32'hEC9A);

    // Backpressure with ready toggling
    do_write(0, 16'h1234);
    do_write(3, 16'hABCD);
    idle();
    mk_exp(8'd2, 10'b00_0000_1001);
    run_frame("bp", 1'b1, -1, -1, 0, 16'h0);

    // Overflow on ch2
    for (int i = 1; i <= 5; i++) do_write(2, 16'(i));
    idle();
    chk("ovf set", 32'(ovf_flag_o), 32'h004);
    for (int f = 0; f < 4; f++) begin
      exp_d[2] = 16'(f + 1);
      mk_exp(8'(3 + f), 10'b00_0000_0100);
      run_frame($sformatf("ovf f%0d", f), 1'b0, -1, -1, 0, 16'h0);
    end
    mk_exp(8'd7, 10'd0);
    run_frame("ovf f4", 1'b0, -1, -1, 0, 16'h0);
    ovf_clr_i = 1'b1;
    idle();
    chk("ovf clr", 32'(ovf_flag_o), 32'h000);

    // Request mid-frame is ignored
    mk_exp(8'd8, 10'd0);
    run_frame("midreq", 1'b0, 5, -1, 0, 16'h0);

    // Write ch5 in the same cycle as its pop
    do_write(5, 16'h5555);
    idle();
    exp_d[5] = 16'h5555;
    mk_exp(8'd9, 10'b00_0010_0000);
    run_frame("popwr", 1'b0, -1, 7, 5, 16'h6666);
    exp_d[5] = 16'h6666;
    mk_exp(8'd10, 10'b00_0010_0000);
    run_frame("popwr next", 1'b0, -1, -1, 0, 16'h0);

    // Overflow coincident with clear keeps the new flag
    for (int i = 0; i < 4; i++) do_write(1, 16'h1100 + 16'(i));
    @(negedge sys_clk_i);
    wr_en_i = 10'b00_0000_0010;
    wr_din_i[16 +: 16] = 16'h11FF;
    ovf_clr_i = 1'b1;
    idle();
    chk("ovf clr collide", 32'(ovf_flag_o), 32'h002);

    // Reset mid-frame (during DATA)
    m_tready_i = 1'b1;
    frame_req_pluse_i = 1'b1;
    @(negedge sys_clk_i);
    frame_req_pluse_i = 1'b0;
    @(negedge sys_clk_i);
    @(negedge sys_clk_i);
    chk("pre abort", {30'd0, m_tvalid_o, busy_o}, 32'd3);
    #1 rst_i = 1'b1;
    #1 chk("abort now", {m_tvalid_o, m_tlast_o, busy_o, ovf_flag_o, m_tdata_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk_i);
      chk($sformatf("abort hold %0d", i), {30'd0, m_tvalid_o, m_tlast_o}, 32'd0);
    end
    rst_i = 1'b0;
    @(negedge sys_clk_i);
    mk_exp(8'd0, 10'd0);
    run_frame("after rst", 1'b0, -1, -1, 0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
